// File: rtl/oled_pkg.sv
// Shared OLED geometry and pixel-tracker state encoding.
package oled_pkg;

   localparam int OLED_WIDTH  = 96;
   localparam int OLED_HEIGHT = 64;
   localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
   localparam int OLED_IDX_W  = 13;
   localparam int OLED_X_W    = 7;
   localparam int OLED_Y_W    = 6;

   typedef enum logic [1:0] {INIT, TRACK, RESYNC, OOR} track_state_t;

endpackage

// File: rtl/coord_divider.sv
// Iterative restoring divider by a constant: one subtraction per cycle.
module coord_divider #(
   parameter int DIVISOR = 96,
   parameter int DIV_W   = 13,
   parameter int Q_W     = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] dividend,
   output logic [Q_W-1:0]   quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             done
);

   localparam logic [DIV_W-1:0] DIV_C = DIV_W'(DIVISOR);

   logic active;

   always_ff @(posedge clock) begin
      if (reset || abort) begin
         active    <= 1'b0;
         remainder <= '0;
         quotient  <= '0;
      end else if (start) begin
         active    <= 1'b1;
         remainder <= dividend;
         quotient  <= '0;
      end else if (active) begin
         if (remainder >= DIV_C) begin
            remainder <= remainder - DIV_C;
            quotient  <= quotient + Q_W'(1);
         end else begin
            active <= 1'b0;
         end
      end
   end

   // Done is presented for exactly the one cycle the result is final.
   assign done = active && (remainder < DIV_C);

endmodule

// File: rtl/pixel_coord_tracker.sv
// Linear OLED pixel index to registered (x, y): counters for +1 steps,
// iterative divider for arbitrary jumps.
module pixel_coord_tracker
   import oled_pkg::*;
#(
   parameter int WIDTH  = OLED_WIDTH,
   parameter int HEIGHT = OLED_HEIGHT,
   parameter int IDX_W  = OLED_IDX_W,
   parameter int X_W    = OLED_X_W,
   parameter int Y_W    = OLED_Y_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] pixel_index,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             coord_valid,
   output logic             frame_start,
   output logic             line_start,
   output logic             busy,
   output logic             out_of_range
);

   // One extra bit so a full 2^IDX_W frame still compares correctly.
   localparam logic [IDX_W:0]   PIXELS = (IDX_W+1)'(WIDTH * HEIGHT);
   localparam logic [X_W-1:0]   X_LAST = X_W'(WIDTH - 1);

   track_state_t     state, state_nxt;
   logic [IDX_W-1:0] prev_idx, prev_nxt;
   logic [IDX_W-1:0] tgt_idx, tgt_nxt;
   logic [X_W-1:0]   x_nxt;
   logic [Y_W-1:0]   y_nxt;
   logic             valid_nxt, fs_nxt, ls_nxt, busy_nxt, oor_nxt;
   logic             div_start, div_abort, div_done;
   logic [Y_W-1:0]   div_q;
   logic [IDX_W-1:0] div_rem;
   logic             idx_oor;

   assign idx_oor = {1'b0, pixel_index} >= PIXELS;

   coord_divider #(
      .DIVISOR (WIDTH),
      .DIV_W   (IDX_W),
      .Q_W     (Y_W)
   ) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .abort     (div_abort),
      .dividend  (pixel_index),
      .quotient  (div_q),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_comb begin
      state_nxt = state;
      prev_nxt  = prev_idx;
      tgt_nxt   = tgt_idx;
      x_nxt     = x;
      y_nxt     = y;
      valid_nxt = coord_valid;
      fs_nxt    = 1'b0;
      ls_nxt    = 1'b0;
      busy_nxt  = busy;
      oor_nxt   = out_of_range;
      div_start = 1'b0;
      div_abort = 1'b0;
      if (idx_oor) begin
         state_nxt = OOR;
         oor_nxt   = 1'b1;
         valid_nxt = 1'b0;
         busy_nxt  = 1'b0;
         div_abort = 1'b1;
      // A held index 0 already being tracked falls through to the hold case,
      // so the frame pulse fires once per arrival.
      end else if (pixel_index == '0 && !(state == TRACK && prev_idx == '0)) begin
         state_nxt = TRACK;
         prev_nxt  = '0;
         x_nxt     = '0;
         y_nxt     = '0;
         valid_nxt = 1'b1;
         fs_nxt    = 1'b1;
         ls_nxt    = 1'b1;
         busy_nxt  = 1'b0;
         oor_nxt   = 1'b0;
         div_abort = 1'b1;
      end else if (state == TRACK && pixel_index == prev_idx) begin
         state_nxt = TRACK;
      end else if (state == TRACK && pixel_index == prev_idx + IDX_W'(1)) begin
         prev_nxt = pixel_index;
         if (x == X_LAST) begin
            x_nxt  = '0;
            y_nxt  = y + Y_W'(1);
            ls_nxt = 1'b1;
         end else begin
            x_nxt = x + X_W'(1);
         end
      end else if (state == RESYNC && pixel_index == tgt_idx) begin
         if (div_done) begin
            state_nxt = TRACK;
            prev_nxt  = tgt_idx;
            x_nxt     = X_W'(div_rem);
            y_nxt     = div_q;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            ls_nxt    = (div_rem == '0);
         end
      end else begin
         state_nxt = RESYNC;
         tgt_nxt   = pixel_index;
         div_start = 1'b1;
         valid_nxt = 1'b0;
         busy_nxt  = 1'b1;
         oor_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= INIT;
         prev_idx     <= '0;
         tgt_idx      <= '0;
         x            <= '0;
         y            <= '0;
         coord_valid  <= 1'b0;
         frame_start  <= 1'b0;
         line_start   <= 1'b0;
         busy         <= 1'b0;
         out_of_range <= 1'b0;
      end else begin
         state        <= state_nxt;
         prev_idx     <= prev_nxt;
         tgt_idx      <= tgt_nxt;
         x            <= x_nxt;
         y            <= y_nxt;
         coord_valid  <= valid_nxt;
         frame_start  <= fs_nxt;
         line_start   <= ls_nxt;
         busy         <= busy_nxt;
         out_of_range <= oor_nxt;
      end
   end

endmodule

// File: tb/tb_pixel_coord_tracker.sv
// Scoreboard bench: driver queues expected coordinates, monitor pops on each new output.
module tb_pixel_coord_tracker;

   localparam int W = 96;
   localparam int H = 64;
   localparam int N = W * H;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] pixel_index = '0;
   logic [6:0]  x;
   logic [5:0]  y;
   logic        coord_valid, frame_start, line_start, busy, out_of_range;

   typedef struct {
      int idx;
      int ex;
      int ey;
      int efs;
      int els;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   sweep_on = 1'b0;
   int   frame_cnt = 0;
   int   line_cnt  = 0;
   int   cur = 0;

   pixel_coord_tracker dut (
      .clock        (clock),
      .reset        (reset),
      .pixel_index  (pixel_index),
      .x            (x),
      .y            (y),
      .coord_valid  (coord_valid),
      .frame_start  (frame_start),
      .line_start   (line_start),
      .busy         (busy),
      .out_of_range (out_of_range)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: row-major geometry, plain division.
   task automatic drive(input int idx, input bit expect_out);
      exp_t e;
      pixel_index = 13'(idx);
      cur = idx;
      if (expect_out) begin
         e.idx = idx;
         e.ex  = idx % W;
         e.ey  = idx / W;
         e.efs = (idx == 0) ? 1 : 0;
         e.els = (idx % W == 0) ? 1 : 0;
         sb.push_back(e);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid(input string name, input int bound);
      for (int k = 0; k < bound && !coord_valid; k++) tick();
      chk(name, int'(coord_valid), 1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_valid"}, int'(coord_valid), 0);
      chk({tag, "_fs"}, int'(frame_start), 0);
      chk({tag, "_ls"}, int'(line_start), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_oor"}, int'(out_of_range), 0);
   endtask

   initial begin : monitor
      bit   pv;
      int   px, py;
      bit   is_new;
      exp_t e;
      pv = 1'b0; px = 0; py = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            pv = 1'b0;
         end else begin
            is_new = coord_valid && (!pv || int'(x) != px || int'(y) != py);
            if (sweep_on) begin
               frame_cnt += int'(frame_start);
               line_cnt  += int'(line_start);
            end
            if (is_new) begin
               if (sb.size() == 0) chk("unexpected_output_queue", sb.size(), 1);
               else begin
                  e = sb.pop_front();
                  chk($sformatf("x_idx%0d", e.idx), int'(x), e.ex);
                  chk($sformatf("y_idx%0d", e.idx), int'(y), e.ey);
                  chk($sformatf("frame_start_idx%0d", e.idx), int'(frame_start), e.efs);
                  chk($sformatf("line_start_idx%0d", e.idx), int'(line_start), e.els);
               end
            end else begin
               chk("idle_pulses", int'({frame_start, line_start}), 0);
            end
            pv = coord_valid; px = int'(x); py = int'(y);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int r;
      reset = 1'b1;
      pixel_index = '0;
      repeat (3) tick();
      chk_reset_state("reset");

      // Sequential walk 0..96, each index held two cycles.
      reset = 1'b0;
      for (int i = 0; i <= 96; i++) begin
         drive(i, 1'b1);
         tick();
         chk($sformatf("valid_seq%0d_a", i), int'(coord_valid), 1);
         if (i % W == 0) chk($sformatf("ls_seq%0d_a", i), int'(line_start), 1);
         tick();
         chk($sformatf("valid_seq%0d_b", i), int'(coord_valid), 1);
         chk($sformatf("ls_seq%0d_b", i), int'(line_start), 0);
      end

      // Back to 10, then jump to the last pixel.
      drive(10, 1'b1);
      tick();
      wait_valid("resync_10", 70);
      tick();
      drive(N - 1, 1'b1);
      tick();
      chk("jump_busy", int'(busy), 1);
      chk("jump_valid_low", int'(coord_valid), 0);
      wait_valid("jump_6143_within_64", 64);
      chk("jump_busy_clear", int'(busy), 0);
      tick();

      // Out of range, then recover to 200.
      drive(N, 1'b0);
      tick();
      chk("oor_flag", int'(out_of_range), 1);
      chk("oor_valid", int'(coord_valid), 0);
      chk("oor_x_hold", int'(x), 95);
      chk("oor_y_hold", int'(y), 63);
      tick();
      drive(200, 1'b1);
      tick();
      chk("oor_exit_flag", int'(out_of_range), 0);
      chk("oor_exit_busy", int'(busy), 1);
      wait_valid("resync_200", 70);
      tick();

      // Abort a resync toward 5000 with index 0.
      drive(5000, 1'b0);
      repeat (3) tick();
      chk("abort_busy_before", int'(busy), 1);
      drive(0, 1'b1);
      tick();
      chk("abort_fs", int'(frame_start), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(coord_valid), 1);
      tick();

      // Reset in the middle of a resync toward 3000.
      drive(3000, 1'b0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk_reset_state("midreset");
      tick();
      reset = 1'b0;
      drive(3000, 1'b1);
      tick();
      wait_valid("resync_3000", 70);
      tick();

      // Full-frame sweep with random hold lengths.
      sweep_on = 1'b1;
      for (int i = 0; i < N; i++) begin
         drive(i, 1'b1);
         repeat ($urandom_range(1, 4)) tick();
      end
      tick();
      @(negedge clock);
      sweep_on = 1'b0;
      chk("sweep_frame_starts", frame_cnt, 1);
      chk("sweep_line_starts", line_cnt, 64);
      tick();

      // Random jumps across the frame.
      for (int j = 0; j < 24; j++) begin
         r = int'($urandom_range(0, N - 1));
         while (r == cur) r = int'($urandom_range(0, N - 1));
         drive(r, 1'b1);
         tick();
         wait_valid($sformatf("rand_jump%0d", j), 70);
         tick();
      end

      repeat (3) tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
